// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_ctrl
// Brief    : Multiplexed common-anode seven-segment driver with hex/decimal
//            display, leading-zero blanking and decimal overflow dashes.
// Revision : 1.0
// ============================================================================
module seg7_scan_ctrl #(
   parameter int DATA_W     = 32,
   parameter int NUM_DIGITS = 8,
   parameter int SCAN_DIV   = 100000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  wr_mode,
   input  logic                  blank_lz,
   output logic                  wr_ack,
   output logic                  busy,
   output logic [NUM_DIGITS-1:0] an,
   output logic [6:0]            seg
);

   localparam int c_NUM_BCD = (DATA_W * 302 + 999) / 1000 + 1;
   localparam int c_BCD_W   = 4 * c_NUM_BCD;
   localparam int c_DISP_W  = 4 * NUM_DIGITS;
   localparam int c_DIV_W   = $clog2(SCAN_DIV);
   localparam int c_IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int c_CNT_W   = $clog2(DATA_W);

   localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
   localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CONV   = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   state_t                           r_state, w_state_nxt;
   logic                             w_accept, w_step, w_commit;
   logic [DATA_W-1:0]                r_data;
   logic                             r_mode, r_blank;
   logic [c_BCD_W-1:0]               r_bcd, w_bcd_adj;
   logic [c_CNT_W-1:0]               r_cnt;
   logic [NUM_DIGITS-1:0][6:0]       r_glyph, w_glyph_nxt;
   logic [c_DISP_W-1:0]              w_hex_ext, w_dec_ext;
   logic                             w_bcd_hi_nz, w_ovf, w_nz_seen;
   logic [3:0]                       w_nib;
   logic [c_DIV_W-1:0]               r_div;
   logic [c_IDX_W-1:0]               r_idx;

   function automatic logic [6:0] f_glyph(input logic [3:0] d);
      case (d)
         4'h0: f_glyph = 7'h40;   4'h1: f_glyph = 7'h79;
         4'h2: f_glyph = 7'h24;   4'h3: f_glyph = 7'h30;
         4'h4: f_glyph = 7'h19;   4'h5: f_glyph = 7'h12;
         4'h6: f_glyph = 7'h02;   4'h7: f_glyph = 7'h78;
         4'h8: f_glyph = 7'h00;   4'h9: f_glyph = 7'h10;
         4'hA: f_glyph = 7'h08;   4'hB: f_glyph = 7'h03;
         4'hC: f_glyph = 7'h46;   4'hD: f_glyph = 7'h21;
         4'hE: f_glyph = 7'h06;   default: f_glyph = 7'h0E;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_step      = 1'b0;
      w_commit    = 1'b0;
      busy        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (wr_en) begin
               w_accept    = 1'b1;
               w_state_nxt = wr_mode ? S_CONV : S_COMMIT;
            end
         end
         S_CONV: begin
            busy   = 1'b1;
            w_step = 1'b1;
            if (r_cnt == c_CNT_LAST) w_state_nxt = S_COMMIT;
         end
         S_COMMIT: begin
            w_commit    = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Double-dabble: add 3 to every BCD digit >= 5 before each left shift.
   always_comb begin
      w_bcd_adj = r_bcd;
      for (int i = 0; i < c_NUM_BCD; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_data  <= '0;
         r_mode  <= 1'b0;
         r_blank <= 1'b0;
         r_bcd   <= '0;
         r_cnt   <= '0;
         wr_ack  <= 1'b0;
         r_glyph <= {NUM_DIGITS{7'h40}};
      end else begin
         wr_ack <= w_accept;
         if (w_accept) begin
            r_data  <= wr_data;
            r_mode  <= wr_mode;
            r_blank <= blank_lz;
            r_bcd   <= '0;
            r_cnt   <= '0;
         end
         if (w_step) begin
            r_bcd  <= (w_bcd_adj << 1) | c_BCD_W'(r_data[DATA_W-1]);
            r_data <= r_data << 1;
            r_cnt  <= r_cnt + c_CNT_W'(1);
         end
         if (w_commit) r_glyph <= w_glyph_nxt;
      end
   end

   generate
      for (genvar j = 0; j < c_DISP_W; j++) begin : g_ext_bits
         if (j < DATA_W) begin : g_hex_src
            assign w_hex_ext[j] = r_data[j];
         end else begin : g_hex_zero
            assign w_hex_ext[j] = 1'b0;
         end
         if (j < c_BCD_W) begin : g_dec_src
            assign w_dec_ext[j] = r_bcd[j];
         end else begin : g_dec_zero
            assign w_dec_ext[j] = 1'b0;
         end
      end
      if (c_NUM_BCD > NUM_DIGITS) begin : g_ovf
         assign w_bcd_hi_nz = |r_bcd[c_BCD_W-1:c_DISP_W];
      end else begin : g_no_ovf
         assign w_bcd_hi_nz = 1'b0;
      end
   endgenerate

   // Walk from the top digit down so blanking stops at the first nonzero digit.
   always_comb begin
      w_ovf       = r_mode & w_bcd_hi_nz;
      w_nz_seen   = 1'b0;
      w_nib       = 4'd0;
      w_glyph_nxt = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         w_nib = r_mode ? w_dec_ext[4*i +: 4] : w_hex_ext[4*i +: 4];
         if (w_ovf)
            w_glyph_nxt[i] = 7'h3F;
         else if (r_blank && !w_nz_seen && (w_nib == 4'd0) && (i != 0))
            w_glyph_nxt[i] = 7'h7F;
         else
            w_glyph_nxt[i] = f_glyph(w_nib);
         w_nz_seen = w_nz_seen | (w_nib != 4'd0);
      end
   end

   // The first divider count of every slot drives all anodes off.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_div <= '0;
         r_idx <= '0;
         an    <= '1;
         seg   <= 7'h7F;
      end else begin
         if (r_div == c_DIV_LAST) begin
            r_div <= '0;
            r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_W'(1);
         end else begin
            r_div <= r_div + c_DIV_W'(1);
         end
         if (r_div == '0) begin
            an  <= '1;
            seg <= 7'h7F;
         end else begin
            an  <= ~(NUM_DIGITS'(1) << r_idx);
            seg <= r_glyph[r_idx];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_ctrl
// Brief    : Randomised bench for seg7_scan_ctrl with a cycle-level display model.
// Revision : 1.0
// ============================================================================
module tb_seg7_scan_ctrl;

   localparam int W = 32;
   localparam int D = 8;
   localparam int S = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1, wr_en = 1'b0, wr_mode = 1'b0, blank_lz = 1'b0;
   logic [W-1:0]  wr_data = '0;
   logic          wr_ack, busy;
   logic [D-1:0]  an;
   logic [6:0]    seg;

   logic          wr_en_s = 1'b0, wr_mode_s = 1'b0, blank_s = 1'b0;
   logic [11:0]   wr_data_s = '0;
   logic          wr_ack_s, busy_s;
   logic [3:0]    an_s;
   logic [6:0]    seg_s;

   seg7_scan_ctrl #(.DATA_W(W), .NUM_DIGITS(D), .SCAN_DIV(S)) u_dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_mode(wr_mode),
      .blank_lz(blank_lz), .wr_ack(wr_ack), .busy(busy), .an(an), .seg(seg));

   seg7_scan_ctrl #(.DATA_W(12), .NUM_DIGITS(4), .SCAN_DIV(3)) u_dut_s (
      .clk(clk), .rst(rst), .wr_en(wr_en_s), .wr_data(wr_data_s), .wr_mode(wr_mode_s),
      .blank_lz(blank_s), .wr_ack(wr_ack_s), .busy(busy_s), .an(an_s), .seg(seg_s));

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Expected glyphs for all eight digits, digit 7 in the top bits.
   function automatic logic [55:0] calc_disp(input logic [31:0] v, input bit m, input bit b);
      int d [8];
      longint unsigned x, p;
      bit ovf;
      int msd;
      logic [55:0] r;
      x = longint'(v);
      p = 1;
      for (int i = 0; i < 8; i++) begin
         d[i] = m ? int'((x / p) % 10) : int'((v >> (4 * i)) & 32'hF);
         p = p * 10;
      end
      ovf = m && (x >= 64'd100000000);
      msd = 0;
      for (int i = 0; i < 8; i++) if (d[i] != 0) msd = i;
      for (int i = 0; i < 8; i++) begin
         if (ovf)                 r[7*i +: 7] = 7'h3F;
         else if (b && (i > msd)) r[7*i +: 7] = 7'h7F;
         else                     r[7*i +: 7] = glyph_tab[d[i]];
      end
      return r;
   endfunction

   // Reference model: time since reset gives scan position; a countdown gives commit time.
   int          mn = 0, phase = 0;
   logic [55:0] m_disp, pend;
   logic [7:0]  e_an;
   logic [6:0]  e_seg;
   bit          e_segchk, e_ack, e_busy, live = 1'b0;

   always @(posedge clk) begin
      int dv, ix;
      if (rst) begin
         mn = 0; phase = 0; m_disp = {8{7'h40}};
         e_an = 8'hFF; e_seg = 7'h7F; e_segchk = 1'b1; e_ack = 1'b0; e_busy = 1'b0;
         live = 1'b1;
      end else begin
         dv = mn % S;
         ix = (mn / S) % D;
         if (dv == 0) begin
            e_an = 8'hFF; e_segchk = 1'b0;
         end else begin
            e_an = ~(8'd1 << ix); e_seg = m_disp[7*ix +: 7]; e_segchk = 1'b1;
         end
         mn++;
         e_ack = 1'b0;
         if (phase == 0) begin
            if (wr_en) begin
               e_ack = 1'b1;
               pend  = calc_disp(wr_data, wr_mode, blank_lz);
               phase = wr_mode ? W + 1 : 1;
            end
         end else begin
            phase--;
            if (phase == 0) m_disp = pend;
         end
         e_busy = (phase > 1);
      end
   end

   always @(negedge clk) begin
      if (live) begin
         check("an", an, e_an);
         if (e_segchk) check("seg", seg, e_seg);
         check("wr_ack", wr_ack, e_ack);
         check("busy", busy, e_busy);
      end
   end

   task automatic do_write(input logic [31:0] v, input logic m, input logic b);
      @(negedge clk);
      wr_en = 1'b1; wr_data = v; wr_mode = m; blank_lz = b;
      @(negedge clk);
      wr_en = 1'b0; wr_data = $urandom;
   endtask

   task automatic wait_an(input logic [7:0] tgt, input string nm);
      int k = 0;
      while (an !== tgt && k < 200) begin
         @(negedge clk);
         k++;
      end
      check({nm, "_an"}, an, tgt);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int cnt, blanks, k;
      check("pin_hex_a5", calc_disp(32'hA5, 1'b0, 1'b0), {{6{7'h40}}, 7'h08, 7'h12});
      check("pin_dec_12345", calc_disp(32'd12345, 1'b1, 1'b1),
            {{3{7'h7F}}, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12});
      check("pin_dec_ovf", calc_disp(32'd100000000, 1'b1, 1'b0), {8{7'h3F}});
      check("pin_dec_zero", calc_disp(32'd0, 1'b1, 1'b1), {{7{7'h7F}}, 7'h40});

      idle(3);
      check("rst_an", an, 8'hFF);
      check("rst_seg", seg, 7'h7F);
      rst = 1'b0;
      idle(2 * D * S);
      wait_an(8'hFE, "t1_d0");  check("t1_d0_seg", seg, 7'h40);
      wait_an(8'h7F, "t1_d7");  check("t1_d7_seg", seg, 7'h40);

      do_write(32'h0000_00A5, 1'b0, 1'b0);
      check("t2_ack", wr_ack, 1'b1);
      idle(3);
      wait_an(8'hFD, "t2_d1");  check("t2_d1_seg", seg, 7'h08);
      wait_an(8'hFE, "t2_d0");  check("t2_d0_seg", seg, 7'h12);
      wait_an(8'h7F, "t2_d7");  check("t2_d7_seg", seg, 7'h40);
      do_write(32'h0000_00A5, 1'b0, 1'b1);
      idle(3);
      wait_an(8'h7F, "t2b_d7"); check("t2b_d7_seg", seg, 7'h7F);
      wait_an(8'hFD, "t2b_d1"); check("t2b_d1_seg", seg, 7'h08);

      do_write(32'd12345, 1'b1, 1'b1);
      cnt = 0;
      while (busy && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      check("t3_busy_len", cnt, 32);
      idle(2);
      wait_an(8'hEF, "t3_d4");  check("t3_d4_seg", seg, 7'h79);
      wait_an(8'hDF, "t3_d5");  check("t3_d5_seg", seg, 7'h7F);

      do_write(32'd100000000, 1'b1, 1'b0);
      idle(40);
      wait_an(8'hFE, "t4_d0");  check("t4_d0_seg", seg, 7'h3F);
      do_write(32'd0, 1'b1, 1'b1);
      idle(40);
      wait_an(8'hFE, "t4b_d0"); check("t4b_d0_seg", seg, 7'h40);
      wait_an(8'hFD, "t4b_d1"); check("t4b_d1_seg", seg, 7'h7F);

      do_write(32'd987654, 1'b1, 1'b0);
      idle(5);
      do_write(32'h0000_FFFF, 1'b0, 1'b0);
      check("t5_no_ack", wr_ack, 1'b0);
      idle(40);
      wait_an(8'hFE, "t5_d0");  check("t5_d0_seg", seg, 7'h19);
      do_write(32'd55555, 1'b1, 1'b0);
      idle(9);
      check("t5_busy_mid", busy, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t5_busy_rst", busy, 1'b0);
      wait_an(8'hFB, "t5_d2");  check("t5_d2_seg", seg, 7'h40);

      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst      = ($urandom_range(0, 999) == 0);
         wr_en    = ($urandom_range(0, 24) == 0);
         wr_mode  = 1'($urandom_range(0, 1));
         blank_lz = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       wr_data = $urandom;
            1:       wr_data = $urandom % 1000;
            2:       wr_data = $urandom % 100000000;
            default: wr_data = $urandom_range(99999990, 100000010);
         endcase
      end
      @(negedge clk);
      rst = 1'b0; wr_en = 1'b0;
      idle(40);

      @(negedge clk);
      wr_en_s = 1'b1; wr_data_s = 12'hABC; wr_mode_s = 1'b0; blank_s = 1'b0;
      @(negedge clk);
      wr_en_s = 1'b0;
      check("t6_ack", wr_ack_s, 1'b1);
      idle(3);
      k = 0;
      while (an_s !== 4'hE && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("t6_find_an", an_s, 4'hE);
      blanks = 0;
      for (int c = 0; c < 12; c++) begin
         case (an_s)
            4'hF:    blanks++;
            4'hE:    check("t6_d0_seg", seg_s, 7'h46);
            4'hD:    check("t6_d1_seg", seg_s, 7'h03);
            4'hB:    check("t6_d2_seg", seg_s, 7'h08);
            4'h7:    check("t6_d3_seg", seg_s, 7'h40);
            default: check("t6_an_onehot", an_s, 4'hF);
         endcase
         @(negedge clk);
      end
      check("t6_blanks", blanks, 4);
      k = 0;
      while (an_s === 4'hE && k < 50) begin @(negedge clk); k++; end
      while (an_s !== 4'hE && k < 50) begin @(negedge clk); k++; end
      k = 0;
      while (an_s === 4'hE && k < 50) begin @(negedge clk); k++; end
      while (an_s !== 4'hE && k < 50) begin @(negedge clk); k++; end
      check("t6_period", k, 12);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
